// File: rtl/router_pkg.sv
// Shared router types and the round-robin pick helper used by egress arbiters and the
// NI scheduler.
package router_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    localparam int unsigned ROUTER_NUM_PORTS = 4;
    localparam int unsigned ROUTER_NI_IDX    = ROUTER_NUM_PORTS;
    localparam int unsigned ROUTER_MAX_REQ   = 32;
    localparam int unsigned ROUTER_IDX_W     = $clog2(ROUTER_MAX_REQ);

    // One-hot first set bit of req[n-1:0], searching upward from ptr and wrapping at n.
    function automatic logic [ROUTER_MAX_REQ-1:0] rr_pick(
        input logic [ROUTER_MAX_REQ-1:0] req,
        input int unsigned               ptr,
        input int unsigned               n
    );
        logic [ROUTER_MAX_REQ-1:0] pick;
        logic                      found;
        int unsigned               idx;
        logic [ROUTER_IDX_W-1:0]   sel;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < ROUTER_MAX_REQ; i++) begin
            idx = ptr + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            sel = idx[ROUTER_IDX_W-1:0];
            if (i < n && !found && req[sel]) begin
                pick[sel] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin priority pick: rotate to ptr, find first, un-rotate.
module rr_priority_pick
    import router_pkg::*;
#(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] pick_o
);

    logic [ROUTER_MAX_REQ-1:0] req_ext;
    logic [ROUTER_MAX_REQ-1:0] pick_ext;
    logic                      unused_pick_hi;

    assign req_ext        = ROUTER_MAX_REQ'(req_i);
    assign pick_ext       = rr_pick(req_ext, 32'(ptr_i), NUM_REQ);
    assign pick_o         = pick_ext[NUM_REQ-1:0];
    assign unused_pick_hi = ^pick_ext[ROUTER_MAX_REQ-1:NUM_REQ];

endmodule

// File: rtl/router_egress_arbiter.sv
// Packet-atomic round-robin arbiter sharing one AXI-Stream egress port among the ingress
// FIFOs and the NI, with a beat-count watchdog that forces release of overlong packets.
module router_egress_arbiter
    import router_pkg::*;
#(
    parameter int unsigned NUM_REQ    = ROUTER_NI_IDX + 1,
    parameter int unsigned PORT_WIDTH = 128,
    parameter int unsigned MAX_BEATS  = 64
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic [NUM_REQ-1:0]            in_tvalid,
    output logic [NUM_REQ-1:0]            in_tready,
    input  logic [NUM_REQ*PORT_WIDTH-1:0] in_tdata,
    input  logic [NUM_REQ-1:0]            in_tlast,
    output logic                          out_tvalid,
    input  logic                          out_tready,
    output logic [PORT_WIDTH-1:0]         out_tdata,
    output logic                          out_tlast,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          err_overlong
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic               err_q;

    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   rr_ptr_next;
    logic               beat;
    logic               watchdog;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i  (in_tvalid),
        .ptr_i  (rr_ptr_q),
        .pick_o (pick)
    );

    always_comb begin
        owner = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner = PTR_W'(i);
            end
        end
    end

    assign rr_ptr_next = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);

    // grant_q is all-zero outside LOCKED, so nothing moves while idle or in reset.
    always_comb begin
        out_tvalid = 1'b0;
        out_tdata  = '0;
        out_tlast  = 1'b0;
        in_tready  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                out_tvalid   = in_tvalid[i];
                out_tdata    = in_tdata[i*PORT_WIDTH +: PORT_WIDTH];
                out_tlast    = in_tlast[i];
                in_tready[i] = out_tready;
            end
        end
    end

    assign beat     = out_tvalid & out_tready;
    assign watchdog = (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) && !out_tlast;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (|in_tvalid) begin
                        grant_q <= pick;
                        state_q <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (beat) begin
                        if (out_tlast || watchdog) begin
                            state_q    <= ARB_IDLE;
                            grant_q    <= '0;
                            beat_cnt_q <= '0;
                            rr_ptr_q   <= rr_ptr_next;
                            err_q      <= watchdog;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant        = grant_q;
    assign busy         = (state_q == ARB_LOCKED);
    assign err_overlong = err_q;

endmodule

// File: tb/tb_router_egress_arbiter.sv
// Bench for router_egress_arbiter: directed scenarios plus randomized traffic, all checked
// each cycle against a packet-level reference model of the arbitration rules.
module tb_router_egress_arbiter;

    localparam int N  = 5;
    localparam int W  = 32;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           arst_n = 1'b0;
    logic [N-1:0]   in_tvalid = '0;
    logic [N-1:0]   in_tready;
    logic [N*W-1:0] in_tdata = '0;
    logic [N-1:0]   in_tlast = '0;
    logic           out_tvalid;
    logic           out_tready = 1'b1;
    logic [W-1:0]   out_tdata;
    logic           out_tlast;
    logic [N-1:0]   grant;
    logic           busy;
    logic           err_overlong;

    always #5 clk = ~clk;

    router_egress_arbiter #(
        .NUM_REQ    (N),
        .PORT_WIDTH (W),
        .MAX_BEATS  (MB)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .in_tvalid    (in_tvalid),
        .in_tready    (in_tready),
        .in_tdata     (in_tdata),
        .in_tlast     (in_tlast),
        .out_tvalid   (out_tvalid),
        .out_tready   (out_tready),
        .out_tdata    (out_tdata),
        .out_tlast    (out_tlast),
        .grant        (grant),
        .busy         (busy),
        .err_overlong (err_overlong)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner index (-1 = idle), round-robin pointer, beats in packet.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_err   = 0;

    // Sources: queue of packet lengths, beat index within head packet, running sequence.
    int       pend[N][$];
    int       bidx[N];
    int       seq[N];
    bit       stall[N];
    bit       rand_mode = 0;
    logic [N-1:0] acc = '0;

    int       cyc = 0;
    logic [N-1:0] gnt_hist[64];
    logic [N-1:0] rdy_hist[64];
    bit       beat_hist[64];
    bit       err_hist[64];
    int       beats_seen[N];
    int       err_count = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] lane_data(input int i);
        int s;
        s = seq[i];
        return {i[7:0], s[23:0]};
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (rand_mode) begin
                if (pend[i].size() == 0 && $urandom_range(0, 3) == 0)
                    pend[i].push_back(int'($urandom_range(1, 6)));
                // An offered beat must stay offered until it is taken.
                if (!(in_tvalid[i] && !acc[i]))
                    in_tvalid[i] = (pend[i].size() > 0) && ($urandom_range(0, 3) != 0);
            end else begin
                in_tvalid[i] = (pend[i].size() > 0) && !stall[i];
            end
            in_tdata[i*W +: W] = lane_data(i);
            in_tlast[i] = 1'b0;
            if (pend[i].size() > 0)
                in_tlast[i] = (bidx[i] == pend[i][0] - 1);
        end
        if (rand_mode) out_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic advance();
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                seq[i]++;
                bidx[i]++;
                if (bidx[i] == pend[i][0]) begin
                    void'(pend[i].pop_front());
                    bidx[i] = 0;
                end
            end
        end
    endtask

    task automatic model_step();
        bit nerr;
        bit found;
        int j;
        nerr = 0;
        if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && in_tvalid[j]) begin
                    m_owner = j;
                    found   = 1;
                end
            end
        end else if (in_tvalid[m_owner] && out_tready) begin
            if (in_tlast[m_owner] || m_cnt == MB - 1) begin
                nerr    = !in_tlast[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end
        m_err = nerr;
    endtask

    task automatic compare_now();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         ev;
        eg = '0;
        er = '0;
        ev = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            er[m_owner] = out_tready;
            ev          = in_tvalid[m_owner];
        end
        chk("grant", 64'(grant), 64'(eg));
        chk("busy", 64'(busy), 64'(m_owner >= 0));
        chk("err_overlong", 64'(err_overlong), 64'(m_err));
        chk("out_tvalid", 64'(out_tvalid), 64'(ev));
        chk("in_tready", 64'(in_tready), 64'(er));
        if (ev) begin
            chk("out_tdata", 64'(out_tdata), 64'(lane_data(m_owner)));
            chk("out_tlast", 64'(out_tlast), 64'(in_tlast[m_owner]));
        end
        acc = in_tvalid & er;
        if (cyc < 64) begin
            gnt_hist[cyc]  = grant;
            rdy_hist[cyc]  = in_tready;
            beat_hist[cyc] = out_tvalid && out_tready;
            err_hist[cyc]  = err_overlong;
        end
        if (out_tvalid && out_tready)
            for (int k = 0; k < N; k++) if (grant[k]) beats_seen[k]++;
        if (err_overlong) err_count++;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_now();
        @(posedge clk);
        model_step();
        #1;
        advance();
        drive_inputs();
        cyc++;
    endtask

    task automatic reset_all();
        arst_n    = 1'b0;
        m_owner   = -1;
        m_ptr     = 0;
        m_cnt     = 0;
        m_err     = 0;
        acc       = '0;
        err_count = 0;
        rand_mode = 0;
        for (int i = 0; i < N; i++) begin
            pend[i].delete();
            bidx[i]       = 0;
            seq[i]        = 0;
            stall[i]      = 0;
            beats_seen[i] = 0;
        end
    endtask

    task automatic release_reset();
        out_tready = 1'b1;
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    initial begin
        logic [N-1:0] e;

        // Reset with every requester asserting valid.
        reset_all();
        out_tready = 1'b1;
        in_tvalid  = '1;
        in_tdata   = {N{32'hdeadbeef}};
        repeat (3) @(negedge clk);
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_out_tvalid", 64'(out_tvalid), 64'(0));
        chk("rst_in_tready", 64'(in_tready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err_overlong), 64'(0));
        release_reset();

        // req0 and req2, 3-beat packets.
        pend[0].push_back(3);
        pend[2].push_back(3);
        drive_inputs();
        repeat (10) cycle();
        chk("t2_idle0", 64'(gnt_hist[0]), 64'(0));
        chk("t2_gnt1", 64'(gnt_hist[1]), 64'(5'b00001));
        chk("t2_beat3", 64'(beat_hist[3]), 64'(1));
        chk("t2_bubble_gnt", 64'(gnt_hist[4]), 64'(0));
        chk("t2_bubble_beat", 64'(beat_hist[4]), 64'(0));
        chk("t2_gnt5", 64'(gnt_hist[5]), 64'(5'b00100));
        chk("t2_beat7", 64'(beat_hist[7]), 64'(1));
        chk("t2_model_ptr", 64'(m_ptr), 64'(3));
        chk("t2_beats0", 64'(beats_seen[0]), 64'(3));
        chk("t2_beats2", 64'(beats_seen[2]), 64'(3));

        // All five with single-beat packets: rotation 0,1,2,3,4,0.
        reset_all();
        release_reset();
        for (int i = 0; i < N; i++) begin
            pend[i].push_back(1);
            pend[i].push_back(1);
        end
        drive_inputs();
        repeat (14) cycle();
        for (int k = 0; k < 6; k++) begin
            e = '0;
            e[k % N] = 1'b1;
            chk($sformatf("t3_gnt%0d", k), 64'(gnt_hist[2*k+1]), 64'(e));
            chk($sformatf("t3_beat%0d", k), 64'(beat_hist[2*k+1]), 64'(1));
            chk($sformatf("t3_gap%0d", k), 64'(beat_hist[2*k+2]), 64'(0));
        end

        // Owner 1 stalled by egress backpressure and its own valid drop.
        reset_all();
        release_reset();
        pend[1].push_back(6);
        drive_inputs();
        repeat (3) cycle();
        pend[0].push_back(2);
        pend[3].push_back(2);
        for (int s = 0; s < 5; s++) begin
            stall[1]   = (s < 3);
            out_tready = 1'b0;
            drive_inputs();
            cycle();
            chk($sformatf("t4_hold_gnt%0d", s), 64'(gnt_hist[cyc-1]), 64'(5'b00010));
            chk($sformatf("t4_hold_rdy%0d", s), 64'(rdy_hist[cyc-1]), 64'(0));
        end
        stall[1]   = 0;
        out_tready = 1'b1;
        drive_inputs();
        repeat (20) cycle();
        chk("t4_beats1", 64'(beats_seen[1]), 64'(6));
        chk("t4_beats0", 64'(beats_seen[0]), 64'(2));
        chk("t4_beats3", 64'(beats_seen[3]), 64'(2));

        // Overlong packet on req3 hits the watchdog after beat 4.
        reset_all();
        release_reset();
        pend[3].push_back(6);
        drive_inputs();
        repeat (12) cycle();
        chk("t5_gnt4", 64'(gnt_hist[4]), 64'(5'b01000));
        chk("t5_release", 64'(gnt_hist[5]), 64'(0));
        chk("t5_err5", 64'(err_hist[5]), 64'(1));
        chk("t5_err_count", 64'(err_count), 64'(1));
        chk("t5_regrant", 64'(gnt_hist[6]), 64'(5'b01000));
        chk("t5_beat7", 64'(beat_hist[7]), 64'(1));
        chk("t5_beats3", 64'(beats_seen[3]), 64'(6));

        // Asynchronous reset in the middle of an NI packet.
        reset_all();
        release_reset();
        pend[4].push_back(4);
        drive_inputs();
        repeat (2) cycle();
        #3;
        reset_all();
        #1;
        chk("t6_grant", 64'(grant), 64'(0));
        chk("t6_out_tvalid", 64'(out_tvalid), 64'(0));
        chk("t6_in_tready", 64'(in_tready), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        release_reset();
        pend[1].push_back(2);
        drive_inputs();
        repeat (4) cycle();
        chk("t6_bubble", 64'(gnt_hist[0]), 64'(0));
        chk("t6_gnt1", 64'(gnt_hist[1]), 64'(5'b00010));
        chk("t6_beat1", 64'(beat_hist[1]), 64'(1));

        // Randomized traffic and backpressure.
        reset_all();
        release_reset();
        rand_mode = 1;
        drive_inputs();
        repeat (3000) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
